// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared core widths and types for the writeback register file.
package wb_regfile_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int PEND_W     = 2;
   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [PEND_W-1:0]     pend_t;
   localparam pend_t PEND_MAX = '1;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback, issue and read-port signals between pipeline and register file.
interface wb_regfile_if;
   import wb_regfile_pkg::*;
   logic     reg_file_write_in;
   reg_idx_t addr_rd;
   word_t    wb_data;
   logic     issue_valid;
   reg_idx_t issue_rd;
   reg_idx_t rs1_addr;
   reg_idx_t rs2_addr;
   logic     rs1_used;
   logic     rs2_used;
   word_t    rs1_data;
   word_t    rs2_data;
   logic     stall;
   logic     err_overflow;
   logic     err_underflow;
   modport master (
      output reg_file_write_in, addr_rd, wb_data, issue_valid, issue_rd,
             rs1_addr, rs2_addr, rs1_used, rs2_used,
      input  rs1_data, rs2_data, stall, err_overflow, err_underflow
   );
   modport slave (
      input  reg_file_write_in, addr_rd, wb_data, issue_valid, issue_rd,
             rs1_addr, rs2_addr, rs1_used, rs2_used,
      output rs1_data, rs2_data, stall, err_overflow, err_underflow
   );
endinterface

// File: rtl/wb_regfile_pend_cnt.sv
// pend_cnt: saturating in-flight write counter with overflow/underflow pulses.
module pend_cnt
   import wb_regfile_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  inc,
   input  logic  dec,
   output pend_t cnt,
   output logic  ovf,
   output logic  unf
);
   logic up, dn;
   always_comb begin
      up  = inc & ~dec & (cnt != PEND_MAX);
      dn  = dec & ~inc & (cnt != '0);
      ovf = inc & ~dec & (cnt == PEND_MAX);
      unf = dec & ~inc & (cnt == '0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (up) cnt <= cnt + 1'b1;
      else if (dn) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 register file with write-through bypass and per-register
// pending-write scoreboard that stalls issue on unresolved sources.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   wb_regfile_if.slave bus
);
   word_t                           regs [NUM_REGS];
   logic [NUM_REGS-1:0][PEND_W-1:0] pend;
   logic [NUM_REGS-1:1]             inc, dec, ovf, unf;
   logic retire, issue, rs1_busy, rs2_busy, stall_int, err_ovf, err_unf;
   assign retire = bus.reg_file_write_in & (bus.addr_rd != '0);
   assign issue  = bus.issue_valid & (bus.issue_rd != '0) & ~stall_int;
   // A last outstanding write retiring this cycle is covered by the bypass.
   assign rs1_busy = (bus.rs1_addr != '0) & (pend[bus.rs1_addr] != '0) &
                     ~((pend[bus.rs1_addr] == pend_t'(1)) & retire & (bus.addr_rd == bus.rs1_addr));
   assign rs2_busy = (bus.rs2_addr != '0) & (pend[bus.rs2_addr] != '0) &
                     ~((pend[bus.rs2_addr] == pend_t'(1)) & retire & (bus.addr_rd == bus.rs2_addr));
   assign stall_int = rst_n & bus.issue_valid &
                      ((bus.rs1_used & rs1_busy) | (bus.rs2_used & rs2_busy));
   assign bus.stall = stall_int;
   assign bus.rs1_data = (!rst_n || bus.rs1_addr == '0) ? '0 :
                         (retire && bus.addr_rd == bus.rs1_addr) ? bus.wb_data : regs[bus.rs1_addr];
   assign bus.rs2_data = (!rst_n || bus.rs2_addr == '0) ? '0 :
                         (retire && bus.addr_rd == bus.rs2_addr) ? bus.wb_data : regs[bus.rs2_addr];
   assign pend[0] = '0;
   for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
      assign inc[i] = issue & (bus.issue_rd == reg_idx_t'(i));
      assign dec[i] = retire & (bus.addr_rd == reg_idx_t'(i));
      pend_cnt u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc[i]),
         .dec   (dec[i]),
         .cnt   (pend[i]),
         .ovf   (ovf[i]),
         .unf   (unf[i])
      );
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         if (retire) regs[bus.addr_rd] <= bus.wb_data;
         err_ovf <= err_ovf | (|ovf);
         err_unf <= err_unf | (|unf);
      end
   end
   assign bus.err_overflow  = err_ovf;
   assign bus.err_underflow = err_unf;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed per-cycle vectors for bypass, scoreboard and error flags,
// plus a hand-written mid-cycle asynchronous reset sequence.
module tb_wb_regfile;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   wb_regfile_if bus ();
   wb_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   typedef struct {
      logic        we;
      logic [4:0]  ad;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  r1a;
      logic        r1u;
      logic [4:0]  r2a;
      logic        r2u;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        es;
      logic        eo;
      logic        eu;
   } vec_t;
   vec_t vq[$];
   function automatic vec_t v(logic we, logic [4:0] ad, logic [31:0] wd, logic iv, logic [4:0] ird,
                              logic [4:0] r1a, logic r1u, logic [4:0] r2a, logic r2u,
                              logic [31:0] e1, logic [31:0] e2, logic es, logic eo, logic eu);
      v = '{we, ad, wd, iv, ird, r1a, r1u, r2a, r2u, e1, e2, es, eo, eu};
   endfunction
   task automatic drive(logic we, logic [4:0] ad, logic [31:0] wd, logic iv, logic [4:0] ird,
                        logic [4:0] r1a, logic r1u, logic [4:0] r2a, logic r2u);
      bus.reg_file_write_in = we;
      bus.addr_rd = ad;
      bus.wb_data = wd;
      bus.issue_valid = iv;
      bus.issue_rd = ird;
      bus.rs1_addr = r1a;
      bus.rs1_used = r1u;
      bus.rs2_addr = r2a;
      bus.rs2_used = r2u;
   endtask
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // post-reset idle probe
      vq.push_back(v(0, 0, 32'h0, 1, 0, 5, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      // x5 write with bypass, x0 write ignored
      vq.push_back(v(0, 0, 32'h0, 1, 5, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(1, 5, 32'hDEADBEEF, 0, 0, 5, 1, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
      vq.push_back(v(1, 0, 32'h00001234, 0, 0, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 0, 0, 0, 0, 5, 0, 32'h0, 32'hDEADBEEF, 0, 0, 0));
      // x7 issue, consumer stalls until retire
      vq.push_back(v(0, 0, 32'h0, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 7, 1, 32'h0, 32'h0, 1, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 7, 1, 32'h0, 32'h0, 1, 0, 0));
      vq.push_back(v(1, 7, 32'hA5A5A5A5, 1, 0, 0, 0, 7, 1, 32'h0, 32'hA5A5A5A5, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 7, 1, 32'h0, 32'hA5A5A5A5, 0, 0, 0));
      // x3 three in flight
      vq.push_back(v(0, 0, 32'h0, 1, 3, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 3, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 3, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(1, 3, 32'h11111111, 1, 0, 3, 1, 0, 0, 32'h11111111, 32'h0, 1, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 3, 1, 0, 0, 32'h11111111, 32'h0, 1, 0, 0));
      vq.push_back(v(1, 3, 32'h22222222, 1, 0, 3, 1, 0, 0, 32'h22222222, 32'h0, 1, 0, 0));
      vq.push_back(v(1, 3, 32'h33333333, 1, 0, 3, 1, 0, 0, 32'h33333333, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 3, 1, 0, 0, 32'h33333333, 32'h0, 0, 0, 0));
      // same-cycle issue/retire on x4 keeps pend at 1; unused sources never stall
      vq.push_back(v(0, 0, 32'h0, 1, 4, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(1, 4, 32'h44444444, 1, 4, 4, 0, 4, 0, 32'h44444444, 32'h44444444, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 4, 0, 4, 0, 32'h44444444, 32'h44444444, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 4, 1, 0, 0, 32'h44444444, 32'h0, 1, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 0, 0, 4, 1, 0, 0, 32'h44444444, 32'h0, 0, 0, 0));
      vq.push_back(v(1, 4, 32'h55555555, 0, 0, 4, 0, 0, 0, 32'h55555555, 32'h0, 0, 0, 0));
      // x9 overflow: pend saturates at 3, three retires drain it
      vq.push_back(v(0, 0, 32'h0, 1, 9, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 9, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 9, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 9, 0, 0, 9, 0, 32'h0, 32'h0, 0, 0, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 9, 1, 0, 0, 32'h0, 32'h0, 1, 1, 0));
      vq.push_back(v(1, 9, 32'h0, 1, 0, 9, 1, 0, 0, 32'h0, 32'h0, 1, 1, 0));
      vq.push_back(v(1, 9, 32'h0, 1, 0, 9, 1, 0, 0, 32'h0, 32'h0, 1, 1, 0));
      vq.push_back(v(1, 9, 32'h0, 1, 0, 9, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 9, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0));
      // x12 underflow still writes
      vq.push_back(v(1, 12, 32'hCAFEF00D, 0, 0, 0, 0, 12, 0, 32'h0, 32'hCAFEF00D, 0, 1, 0));
      vq.push_back(v(0, 0, 32'h0, 1, 0, 5, 0, 12, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1, 1));
      // reset state, with writes and issues presented during reset
      @(negedge clk);
      drive(1, 5, 32'hFFFFFFFF, 1, 5, 5, 1, 5, 1);
      #2;
      chk("rst rs1_data", bus.rs1_data, 32'h0);
      chk("rst rs2_data", bus.rs2_data, 32'h0);
      chk("rst stall", {31'h0, bus.stall}, 32'h0);
      chk("rst err_overflow", {31'h0, bus.err_overflow}, 32'h0);
      chk("rst err_underflow", {31'h0, bus.err_underflow}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      foreach (vq[n]) begin
         @(negedge clk);
         drive(vq[n].we, vq[n].ad, vq[n].wd, vq[n].iv, vq[n].ird, vq[n].r1a, vq[n].r1u, vq[n].r2a, vq[n].r2u);
         #2;
         chk($sformatf("v%0d rs1_data", n), bus.rs1_data, vq[n].e1);
         chk($sformatf("v%0d rs2_data", n), bus.rs2_data, vq[n].e2);
         chk($sformatf("v%0d stall", n), {31'h0, bus.stall}, {31'h0, vq[n].es});
         chk($sformatf("v%0d err_overflow", n), {31'h0, bus.err_overflow}, {31'h0, vq[n].eo});
         chk($sformatf("v%0d err_underflow", n), {31'h0, bus.err_underflow}, {31'h0, vq[n].eu});
      end
      // mid-cycle reset with two writes pending on x6
      @(negedge clk);
      drive(0, 0, 0, 1, 6, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 6, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 6, 1, 5, 0);
      #2;
      chk("pre-rst stall", {31'h0, bus.stall}, 32'h1);
      chk("pre-rst rs2_data", bus.rs2_data, 32'hDEADBEEF);
      chk("pre-rst err_overflow", {31'h0, bus.err_overflow}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("async stall", {31'h0, bus.stall}, 32'h0);
      chk("async rs1_data", bus.rs1_data, 32'h0);
      chk("async rs2_data", bus.rs2_data, 32'h0);
      chk("async err_overflow", {31'h0, bus.err_overflow}, 32'h0);
      chk("async err_underflow", {31'h0, bus.err_underflow}, 32'h0);
      @(negedge clk);
      drive(1, 5, 32'hFFFFFFFF, 1, 6, 0, 0, 5, 0);
      #2;
      chk("in-rst bypass rs2_data", bus.rs2_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 6, 1, 5, 1);
      #2;
      chk("post-rst stall", {31'h0, bus.stall}, 32'h0);
      chk("post-rst rs1_data", bus.rs1_data, 32'h0);
      chk("post-rst rs2_data", bus.rs2_data, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
